// File: rtl/astable_555_vco_multi.sv
// Multi-channel 555 astable VCO. One LOAD/MUL/UPD datapath is time-shared across all
// channels, and each audio strobe advances every capacitor by one sample.
module astable_555_vco_multi #(
  parameter int CHANNELS    = 4,
  parameter int CLOCK_RATE  = 1000000,
  parameter int K_CHARGE    = 2048,
  parameter int K_DISCHARGE = 4096,
  parameter int VCTRL_MIN   = 512,
  parameter int OUT_HIGH    = 16383,
  parameter int OUT_LOW     = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     audio_clk_en,
  input  logic [16*CHANNELS-1:0]   v_control,
  input  logic [CHANNELS-1:0]      ch_enable,
  output logic [16*CHANNELS-1:0]   out,
  output logic                     sample_valid,
  output logic                     busy,
  output logic                     overrun
);

  localparam int                 IW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [IW-1:0]      LAST       = IW'(CHANNELS - 1);
  localparam logic signed [15:0] VMIN       = 16'(VCTRL_MIN);
  localparam logic [31:0]        KC         = 32'(K_CHARGE);
  localparam logic [31:0]        KD         = 32'(K_DISCHARGE);
  localparam logic [15:0]        OUT_HIGH_W = 16'(OUT_HIGH);
  localparam logic [15:0]        OUT_LOW_W  = 16'(OUT_LOW);

  if (CLOCK_RATE < 3 * CHANNELS + 2) begin : g_budget_check
    $error("CLOCK_RATE too low for one sweep per sample");
  end

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MUL, S_UPD, S_DONE} state_e;

  state_e                   state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [14:0]              cap_q [CHANNELS];
  logic [CHANNELS-1:0]      chg_q;
  logic [14:0]              cur_cap_q, vth_q, vth_d;
  logic                     cur_chg_q, cur_en_q;
  logic [15:0]              step_q, step_d;
  logic [16*CHANNELS-1:0]   shadow_q, shadow_d, out_q;
  logic                     overrun_q;

  logic signed [15:0]       v_arr [CHANNELS];
  logic signed [15:0]       v_lane;
  logic [14:0]              operand, new_cap;
  logic [31:0]              prod;
  logic [16:0]              sum;
  logic                     new_chg;
  logic [15:0]              lane_val;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lanes
    assign v_arr[g] = v_control[16*g +: 16];
  end

  // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: if (audio_clk_en) begin
        state_d = S_LOAD;
        idx_d   = '0;
      end
      S_LOAD: state_d = S_MUL;
      S_MUL:  state_d = S_UPD;
      S_UPD: begin
        if (idx_q == LAST) begin
          state_d = S_DONE;
        end else begin
          state_d = S_LOAD;
          idx_d   = idx_q + IW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The thresholds track v_control. The step is an exponential RC approach toward Vcc or 0.
  always_comb begin
    v_lane  = v_arr[idx_q];
    vth_d   = (v_lane < VMIN) ? 15'(VCTRL_MIN) : v_lane[14:0];

    operand = cur_chg_q ? (15'h7fff - cur_cap_q) : cur_cap_q;
    prod    = 32'(operand) * (cur_chg_q ? KC : KD);
    step_d  = 16'(prod >> 16);
    if (step_d == 16'd0 && operand != 15'd0) step_d = 16'd1;

    sum = 17'(cur_cap_q) + 17'(step_q);
    if (cur_chg_q) begin
      new_cap = (sum > 17'd32767) ? 15'h7fff : sum[14:0];
    end else begin
      new_cap = (17'(cur_cap_q) < 17'(step_q)) ? 15'd0 : (cur_cap_q - step_q[14:0]);
    end

    new_chg = cur_chg_q;
    if (cur_chg_q && new_cap >= vth_q) new_chg = 1'b0;
    else if (!cur_chg_q && new_cap <= (vth_q >> 1)) new_chg = 1'b1;

    if (!cur_en_q) begin
      new_cap = '0;
      new_chg = 1'b1;
    end

    lane_val = (cur_en_q && new_chg) ? OUT_HIGH_W : OUT_LOW_W;
    shadow_d = shadow_q;
    shadow_d[16*int'(idx_q) +: 16] = lane_val;
  end

  // NOTE: the per-channel state array is reset explicitly, because the oscillators must restart from cap=0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      for (int i = 0; i < CHANNELS; i++) cap_q[i] <= '0;
      chg_q     <= '1;
      cur_cap_q <= '0;
      cur_chg_q <= 1'b1;
      cur_en_q  <= 1'b0;
      vth_q     <= '0;
      step_q    <= '0;
      shadow_q  <= '0;
      out_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (audio_clk_en && state_q != S_IDLE) overrun_q <= 1'b1;
      unique case (state_q)
        S_LOAD: begin
          cur_cap_q <= cap_q[idx_q];
          cur_chg_q <= chg_q[idx_q];
          cur_en_q  <= ch_enable[idx_q];
          vth_q     <= vth_d;
        end
        S_MUL: step_q <= step_d;
        S_UPD: begin
          cap_q[idx_q] <= new_cap;
          chg_q[idx_q] <= new_chg;
          shadow_q     <= shadow_d;
          // All lanes publish together, and the final channel joins on the same edge.
          if (idx_q == LAST) out_q <= shadow_d;
        end
        default: ;
      endcase
    end
  end

  assign out          = out_q;
  assign busy         = (state_q != S_IDLE);
  assign sample_valid = (state_q == S_DONE);
  assign overrun      = overrun_q;

endmodule
